// File: rtl/databuf_decimator_pkg.sv
// Shared constants for the data-buffer decimator: register address, sizing, status bit, FSM states.
package databuf_decimator_pkg;

    localparam int NUM_CHAN    = 4;
    localparam int LOG2N_MAX   = 6;
    localparam int ACC_W       = 16 + LOG2N_MAX;
    localparam int OVERRUN_BIT = 7;

    localparam logic [15:0] CFG_ADDR    = 16'h7801;
    localparam logic [2:0]  LOG2N_MAX_3 = 3'(LOG2N_MAX);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [2:0] clamp_log2n(input logic [2:0] raw);
        return (raw > LOG2N_MAX_3) ? LOG2N_MAX_3 : raw;
    endfunction

endpackage

// File: rtl/databuf_decim_chan.sv
// One channel of the boxcar decimator: 22-bit accumulator plus the shift (or round-and-shift) to 16 bits.
// Rounding is built only when DATABUF_DECIM_ROUND_EN is defined; otherwise the average is truncated.
module databuf_decim_chan
    import databuf_decimator_pkg::*;
(
    input  logic        clkbuffer,
    input  logic        reset,
    input  logic        clear,
    input  logic        add,
    input  logic        shift,
    input  logic [2:0]  log2n,
    input  logic [15:0] sample,
    output logic [15:0] data_out
);

    logic [ACC_W-1:0] acc_reg;
    logic [15:0]      data_out_reg;
    logic [15:0]      avg_next;

`ifdef DATABUF_DECIM_ROUND_EN
    localparam logic [ACC_W:0] RND_ONE = 1;
    logic [ACC_W:0] rnd_sum;
    logic [ACC_W:0] rnd_shift;

    // Round half up; the clip can never trigger for legal sums but keeps the result bounded.
    always_comb begin
        rnd_sum = {1'b0, acc_reg};
        if (log2n != 3'd0) begin
            rnd_sum = rnd_sum + (RND_ONE << (log2n - 3'd1));
        end
        rnd_shift = rnd_sum >> log2n;
        avg_next  = (|rnd_shift[ACC_W:16]) ? 16'hFFFF : rnd_shift[15:0];
    end
`else
    always_comb begin
        avg_next = 16'(acc_reg >> log2n);
    end
`endif

    always_ff @(posedge clkbuffer or negedge reset) begin
        if (!reset) begin
            acc_reg      <= '0;
            data_out_reg <= '0;
        end else if (shift) begin
            data_out_reg <= avg_next;
            acc_reg      <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (add) begin
            acc_reg <= acc_reg + {{(ACC_W-16){1'b0}}, sample};
        end
    end

    assign data_out = data_out_reg;

endmodule

// File: rtl/databuf_decimator.sv
// Averages 2^log2n ADC sample sets per channel and hands each result to the data collection buffer.
// Optional round-half-up averaging: define DATABUF_DECIM_ROUND_EN.
module databuf_decimator
    import databuf_decimator_pkg::*;
(
    input  logic        clkbuffer,
    input  logic        reset,
    input  logic        adc_valid,
    input  logic [15:0] adc_data1,
    input  logic [15:0] adc_data2,
    input  logic [15:0] adc_data3,
    input  logic [15:0] adc_data4,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic        data_fb_wen,
    output logic [15:0] data_out1,
    output logic [15:0] data_out2,
    output logic [15:0] data_out3,
    output logic [15:0] data_out4
);

    state_t      state_reg;
    logic [6:0]  count_reg;
    logic [2:0]  log2n_reg;
    logic        overrun_reg;
    logic        data_fb_wen_reg;

    logic        cfg_write;
    logic        in_accum;
    logic [6:0]  group_len;
    logic [6:0]  count_next;
    logic        ch_clear;
    logic        ch_add;
    logic        ch_shift;

    logic [15:0] adc_data_arr [NUM_CHAN];
    logic [15:0] chan_out     [NUM_CHAN];

    assign cfg_write  = reg_wen && (reg_waddr == CFG_ADDR);
    assign in_accum   = (state_reg == ST_ACCUM);
    assign group_len  = 7'd1 << log2n_reg;
    assign count_next = count_reg + 7'd1;

    // A config write in ACCUM restarts the group and swallows any coincident sample.
    assign ch_clear = cfg_write && in_accum;
    assign ch_add   = adc_valid && !cfg_write && in_accum;
    assign ch_shift = (state_reg == ST_SHIFT);

    always_ff @(posedge clkbuffer or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_ACCUM;
            count_reg       <= '0;
            log2n_reg       <= '0;
            overrun_reg     <= 1'b0;
            data_fb_wen_reg <= 1'b0;
        end else begin
            data_fb_wen_reg <= 1'b0;

            if (cfg_write) begin
                log2n_reg   <= clamp_log2n(reg_wdata[2:0]);
                overrun_reg <= 1'b0;
            end else if (adc_valid && !in_accum) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_ACCUM: begin
                    if (cfg_write) begin
                        count_reg <= '0;
                    end else if (adc_valid) begin
                        count_reg <= count_next;
                        if (count_next == group_len) begin
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    count_reg       <= '0;
                    data_fb_wen_reg <= 1'b1;
                    state_reg       <= ST_EMIT;
                end
                ST_EMIT: begin
                    state_reg <= ST_GAP;
                end
                default: begin
                    state_reg <= ST_ACCUM;
                end
            endcase
        end
    end

    assign adc_data_arr[0] = adc_data1;
    assign adc_data_arr[1] = adc_data2;
    assign adc_data_arr[2] = adc_data3;
    assign adc_data_arr[3] = adc_data4;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            databuf_decim_chan u_chan (
                .clkbuffer (clkbuffer),
                .reset     (reset),
                .clear     (ch_clear),
                .add       (ch_add),
                .shift     (ch_shift),
                .log2n     (log2n_reg),
                .sample    (adc_data_arr[gi]),
                .data_out  (chan_out[gi])
            );
        end
    endgenerate

    assign data_out1   = chan_out[0];
    assign data_out2   = chan_out[1];
    assign data_out3   = chan_out[2];
    assign data_out4   = chan_out[3];
    assign data_fb_wen = data_fb_wen_reg;

    always_comb begin
        reg_rdata = '0;
        if (reg_raddr == CFG_ADDR) begin
            reg_rdata[OVERRUN_BIT] = overrun_reg;
            reg_rdata[2:0]         = log2n_reg;
        end
    end

endmodule

// File: tb/tb_databuf_decimator.sv
// Directed bench for databuf_decimator; expected values are hand-computed from the behaviour description.
module tb_databuf_decimator;

    logic        clkbuffer = 1'b0;
    logic        reset     = 1'b0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data1 = '0;
    logic [15:0] adc_data2 = '0;
    logic [15:0] adc_data3 = '0;
    logic [15:0] adc_data4 = '0;
    logic [15:0] reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_wen   = 1'b0;
    logic [15:0] reg_raddr = 16'h7801;
    logic [31:0] reg_rdata;
    logic        data_fb_wen;
    logic [15:0] data_out1;
    logic [15:0] data_out2;
    logic [15:0] data_out3;
    logic [15:0] data_out4;

    int checks_total  = 0;
    int checks_passed = 0;
    int strobe_cnt    = 0;
    int strobe_base   = 0;

    always #5 clkbuffer = ~clkbuffer;

    databuf_decimator dut (
        .clkbuffer   (clkbuffer),
        .reset       (reset),
        .adc_valid   (adc_valid),
        .adc_data1   (adc_data1),
        .adc_data2   (adc_data2),
        .adc_data3   (adc_data3),
        .adc_data4   (adc_data4),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .reg_wen     (reg_wen),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .data_fb_wen (data_fb_wen),
        .data_out1   (data_out1),
        .data_out2   (data_out2),
        .data_out3   (data_out3),
        .data_out4   (data_out4)
    );

    always @(negedge clkbuffer) begin
        if (data_fb_wen) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
            $display("ok   %-22s observed=%h expected=%h", tag, observed, expected);
        end else begin
            $display("FAIL %-22s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clkbuffer);
    endtask

    task automatic send_sample(input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] d3, input logic [15:0] d4);
        adc_valid = 1'b1;
        adc_data1 = d1;
        adc_data2 = d2;
        adc_data3 = d3;
        adc_data4 = d4;
        @(negedge clkbuffer);
        adc_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [31:0] wdata);
        reg_wen   = 1'b1;
        reg_waddr = 16'h7801;
        reg_wdata = wdata;
        @(negedge clkbuffer);
        reg_wen   = 1'b0;
    endtask

    task automatic strobes_since(input string tag, input int expected);
        check(tag, 32'(strobe_cnt - strobe_base), 32'(expected));
        strobe_base = strobe_cnt;
    endtask

    initial begin
        // Reset state
        wait_cycles(2);
        check("rst_fb_wen", {31'd0, data_fb_wen}, 32'd0);
        check("rst_data_out1", {16'd0, data_out1}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        reset = 1'b1;
        wait_cycles(2);

        // Pass-through: strobe exactly two cycles after the sample cycle
        send_sample(16'h1234, 16'h0001, 16'hFFFF, 16'h0000);
        check("pt_fb_wen_t1", {31'd0, data_fb_wen}, 32'd0);
        @(negedge clkbuffer);
        check("pt_fb_wen_t2", {31'd0, data_fb_wen}, 32'd1);
        check("pt_data_out1", {16'd0, data_out1}, 32'h1234);
        check("pt_data_out2", {16'd0, data_out2}, 32'h0001);
        check("pt_data_out3", {16'd0, data_out3}, 32'hFFFF);
        check("pt_data_out4", {16'd0, data_out4}, 32'h0000);
        @(negedge clkbuffer);
        check("pt_fb_wen_t3", {31'd0, data_fb_wen}, 32'd0);
        wait_cycles(3);
        strobes_since("pt_strobes", 1);

        // log2n=2: 10+11+12+13 = 46, /4 = 11.5
        cfg_write(32'd2);
        check("cfg2_rdata", reg_rdata, 32'd2);
        send_sample(16'd10, 16'd0, 16'd0, 16'd0);
        send_sample(16'd11, 16'd0, 16'd0, 16'd0);
        send_sample(16'd12, 16'd0, 16'd0, 16'd0);
        send_sample(16'd13, 16'd0, 16'd0, 16'd0);
        wait_cycles(5);
        strobes_since("avg4_strobes", 1);
`ifdef DATABUF_DECIM_ROUND_EN
        check("avg4_data_out1", {16'd0, data_out1}, 32'd12);
`else
        check("avg4_data_out1", {16'd0, data_out1}, 32'd11);
`endif

        // Clamp 7 -> 6, then 64 full-scale samples must not wrap
        cfg_write(32'd7);
        check("clamp_rdata", reg_rdata, 32'd6);
        for (int i = 0; i < 63; i++) send_sample(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_cycles(3);
        strobes_since("max_strobes_63", 0);
        send_sample(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_cycles(5);
        strobes_since("max_strobes_64", 1);
        check("max_data_out1", {16'd0, data_out1}, 32'hFFFF);
        check("max_data_out4", {16'd0, data_out4}, 32'hFFFF);

        // log2n=0, samples every 2 cycles: 2nd and 4th land in EMIT and are dropped
        cfg_write(32'd0);
        for (int i = 1; i <= 4; i++) begin
            send_sample(16'(i), 16'd0, 16'd0, 16'd0);
            @(negedge clkbuffer);
        end
        wait_cycles(5);
        strobes_since("ovr_strobes", 2);
        check("ovr_data_out1", {16'd0, data_out1}, 32'd3);
        check("ovr_rdata_set", reg_rdata, 32'h80);
        reg_raddr = 16'h7800;
        #1;
        check("other_addr_rdata", reg_rdata, 32'd0);
        reg_raddr = 16'h7801;
        cfg_write(32'd0);
        check("ovr_rdata_clear", reg_rdata, 32'd0);

        // Mid-group config write discards the partial sum
        cfg_write(32'd3);
        for (int i = 0; i < 5; i++) send_sample(16'd100, 16'd0, 16'd0, 16'd0);
        wait_cycles(3);
        strobes_since("restart_strobes_pre", 0);
        cfg_write(32'd1);
        check("restart_rdata", reg_rdata, 32'd1);
        send_sample(16'd20, 16'd0, 16'd0, 16'd0);
        send_sample(16'd30, 16'd0, 16'd0, 16'd0);
        wait_cycles(5);
        strobes_since("restart_strobes", 1);
        check("restart_data_out1", {16'd0, data_out1}, 32'd25);

        // Reset asserted while data_fb_wen is high
        send_sample(16'd40, 16'd0, 16'd0, 16'd0);
        send_sample(16'd42, 16'd0, 16'd0, 16'd0);
        @(negedge clkbuffer);
        check("emit_fb_wen", {31'd0, data_fb_wen}, 32'd1);
        check("emit_data_out1", {16'd0, data_out1}, 32'd41);
        #2;
        reset = 1'b0;
        #1;
        check("arst_fb_wen", {31'd0, data_fb_wen}, 32'd0);
        check("arst_data_out1", {16'd0, data_out1}, 32'd0);
        check("arst_rdata", reg_rdata, 32'd0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(2);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
